// File: rtl/vedic_mul_cla32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vedic_mul_cla32_pkg : shared widths for the Vedic CLA multiplier      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package vedic_mul_cla32_pkg;

    localparam int VM_WIDTH  = 32;
    localparam int VM_PROD_W = 2 * VM_WIDTH;

    typedef logic [VM_PROD_W-1:0] vm_prod_t;

endpackage
`default_nettype wire

// File: rtl/vedic_mul_cla32_cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cla_adder : W-bit carry-lookahead adder, 4-bit groups, carry-in 0     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cla_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    // W is always a multiple of 4 where this adder is used.
    localparam int NG = W / 4;

    logic [W-1:0]  g;
    logic [W-1:0]  p;
    logic [W-1:0]  cy;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;

    // Group and bit carries are flat sums of products, not chained.
    always_comb begin
        logic term;
        logic cb;
        term = 1'b0;
        cb   = 1'b0;
        g    = x_i & y_i;
        p    = x_i ^ y_i;
        gg   = '0;
        gc   = '0;
        cy   = '0;
        for (int grp = 0; grp < NG; grp++) begin
            gg[grp] = g[4*grp+3]
                    | (p[4*grp+3] & g[4*grp+2])
                    | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                    | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp]);
        end
        for (int grp = 1; grp <= NG; grp++) begin
            for (int k = 0; k < grp; k++) begin
                term = gg[k];
                for (int m = k + 1; m < grp; m++) begin
                    term = term & (&p[4*m +: 4]);
                end
                gc[grp] = gc[grp] | term;
            end
        end
        for (int grp = 0; grp < NG; grp++) begin
            for (int bt = 0; bt < 4; bt++) begin
                cb = gc[grp];
                for (int m = 0; m < bt; m++) begin
                    cb = cb & p[4*grp+m];
                end
                for (int k = 0; k < bt; k++) begin
                    term = g[4*grp+k];
                    for (int m = k + 1; m < bt; m++) begin
                        term = term & p[4*grp+m];
                    end
                    cb = cb | term;
                end
                cy[4*grp+bt] = cb;
            end
        end
    end

    assign sum_o  = p ^ cy;
    assign cout_o = gc[NG];

endmodule
`default_nettype wire

// File: rtl/vedic_mul_cla32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vedic_mul_cla32 : unsigned WIDTH x WIDTH Urdhva-Tiryagbhyam multiplier|
// |                   with CLA summation and a registered product         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vedic_mul_cla32
    import vedic_mul_cla32_pkg::*;
#(
    parameter int WIDTH = VM_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] c
);

    localparam int LEVELS = $clog2(WIDTH);

    logic [2*WIDTH-1:0] c_d;
    logic [2*WIDTH-1:0] c_q;

    // Level k holds every (a-chunk i, b-chunk j) product of width 2^k.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N = 1 << k;
        localparam int M = WIDTH / N;
        for (genvar i = 0; i < M; i++) begin : g_row
            for (genvar j = 0; j < M; j++) begin : g_col
                logic [2*N-1:0] w_prod;
                if (k == 1) begin : g_base
                    logic w_t1;
                    logic w_t2;
                    logic w_t3;
                    logic w_c1;
                    assign w_t1   = a[2*i+1] & b[2*j];
                    assign w_t2   = a[2*i]   & b[2*j+1];
                    assign w_t3   = a[2*i+1] & b[2*j+1];
                    assign w_c1   = w_t1 & w_t2;
                    assign w_prod = {w_t3 & w_c1, w_t3 ^ w_c1, w_t1 ^ w_t2, a[2*i] & b[2*j]};
                end else begin : g_node
                    localparam int H = N / 2;
                    logic [N-1:0] w_ll;
                    logic [N-1:0] w_hl;
                    logic [N-1:0] w_lh;
                    logic [N-1:0] w_hh;
                    logic [N-1:0] w_mid_sum;
                    logic         w_mid_co;
                    logic         w_fin_co_unused;

                    assign w_ll = g_lvl[k-1].g_row[2*i].g_col[2*j].w_prod;
                    assign w_hl = g_lvl[k-1].g_row[2*i+1].g_col[2*j].w_prod;
                    assign w_lh = g_lvl[k-1].g_row[2*i].g_col[2*j+1].w_prod;
                    assign w_hh = g_lvl[k-1].g_row[2*i+1].g_col[2*j+1].w_prod;

                    cla_adder #(.W(N)) u_mid (
                        .x_i    (w_hl),
                        .y_i    (w_lh),
                        .sum_o  (w_mid_sum),
                        .cout_o (w_mid_co)
                    );

                    // {HH,LL} is LL + HH<<N; the final sum cannot overflow 2N bits.
                    cla_adder #(.W(2*N)) u_fin (
                        .x_i    ({w_hh, w_ll}),
                        .y_i    ({{(H-1){1'b0}}, w_mid_co, w_mid_sum, {H{1'b0}}}),
                        .sum_o  (w_prod),
                        .cout_o (w_fin_co_unused)
                    );
                end
            end
        end
    end

    assign c_d = g_lvl[LEVELS].g_row[0].g_col[0].w_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    assign c = c_q;

endmodule
`default_nettype wire

// File: tb/tb_vedic_mul_cla32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vedic_mul_cla32 : scoreboard bench for the Vedic CLA multiplier    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_vedic_mul_cla32;
    import vedic_mul_cla32_pkg::*;

    localparam int W = VM_WIDTH;

    typedef struct {
        string    tag;
        vm_prod_t value;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    vm_prod_t       c;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vedic_mul_cla32 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c)
    );

    function automatic vm_prod_t ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        vm_prod_t xe;
        vm_prod_t ye;
        xe = {{W{1'b0}}, x};
        ye = {{W{1'b0}}, y};
        return xe * ye;
    endfunction

    task automatic check(input string name, input vm_prod_t act, input vm_prod_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, req);
        end
    endtask

    // Drive one operand pair for exactly one capturing edge.
    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y,
                         input vm_prod_t req, input string tag);
        a = x;
        b = y;
        exp_q.push_back('{tag, req});
        @(posedge clk);
        #1;
    endtask

    // Monitor: every capturing edge presents one product to compare.
    always begin
        @(posedge clk);
        if (rst_n === 1'b1 && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            #1;
            check(e.tag, c, e.value);
        end
    end

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        vm_prod_t     p;
        string        tag;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{32'd0,          32'd14,         64'd0,                     "zero_a"});
        vecs.push_back('{32'd13,         32'd37,         64'd481,                   "13x37"});
        vecs.push_back('{32'd116,        32'd63,         64'd7308,                  "116x63"});
        vecs.push_back('{32'd67,         32'd49,         64'd3283,                  "67x49"});
        vecs.push_back('{32'd119,        32'd8,          64'd952,                   "119x8"});
        vecs.push_back('{32'd8,          32'd9,          64'd72,                    "8x9"});
        vecs.push_back('{32'd16777210,   32'd1048531,    64'd17591424778510,        "wide_carry"});
        vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001,   "max_x_max"});
        vecs.push_back('{32'h0000_FFFF,  32'h0001_0000,  64'h0000_0000_FFFF_0000,   "half_bound"});
        vecs.push_back('{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000,   "msb_x2"});
        vecs.push_back('{32'hDEAD_BEEF,  32'd0,          64'd0,                     "zero_b"});

        rst_n = 1'b0;
        a     = 32'd5;
        b     = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", c, '0);
        @(posedge clk);
        #1;
        check("reset_hold2", c, '0);

        @(negedge clk);
        exp_q.push_back('{"reset_release", 64'd35});
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(vecs[i].x, vecs[i].y, vecs[i].p, vecs[i].tag);

        for (int n = 0; n < 500; n++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = $urandom();
            y = $urandom();
            apply(x, y, ref_mul(x, y), "random");
        end

        apply(32'hFFFF_FFFF, 32'h1234_5678, ref_mul(32'hFFFF_FFFF, 32'h1234_5678), "pre_async");
        #1;
        rst_n = 1'b0;
        #2;
        check("async_reset", c, '0);
        repeat (2) @(posedge clk);
        #1;
        check("async_hold", c, '0);
        @(negedge clk);
        a = 32'd116;
        b = 32'd63;
        exp_q.push_back('{"async_release", 64'd7308});
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 500; n++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = $urandom();
            y = $urandom();
            apply(x, y, ref_mul(x, y), "random");
        end

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
